// File: rtl/reg_arb_pkg.sv
// Shared definitions for the register-file read-port arbiter: requester count,
// index width, FSM states and the modulo-5 increment helper.
package reg_arb_pkg;

  localparam int N_REQ = 5;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  // Out-of-range inputs (5..7) also fold back to 0.
  function automatic logic [IDX_W-1:0] inc_mod(input logic [IDX_W-1:0] v);
    return (v >= IDX_W'(N_REQ - 1)) ? '0 : v + IDX_W'(1);
  endfunction

endpackage

// File: rtl/rr_pick5.sv
// Combinational round-robin picker: first set request bit scanning from ptr
// upward, modulo 5. Produces one-hot pick, its binary index and an any flag.
module rr_pick5
  import reg_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] pick,
  output logic [IDX_W-1:0] pick_id,
  output logic             any
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    pick    = '0;
    pick_id = '0;
    any     = 1'b0;
    idx     = ptr;
    for (int k = 0; k < N_REQ; k++) begin
      if (!any && (idx < IDX_W'(N_REQ)) && req[idx]) begin
        pick[idx] = 1'b1;
        pick_id   = idx;
        any       = 1'b1;
      end
      idx = inc_mod(idx);
    end
  end

endmodule

// File: rtl/reg_port_arbiter.sv
// Round-robin arbiter for the shared register-file read port (five requesters).
// Optional grant tenure limit enabled by defining ARB_HOLD_LIMIT_EN.
module reg_port_arbiter
  import reg_arb_pkg::*;
#(
  parameter int DATA_W   = 3,
  parameter int HOLD_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  input  logic [DATA_W-1:0] data3,
  input  logic [DATA_W-1:0] data4,
  output logic [N_REQ-1:0]  gnt,
  output logic              gnt_valid,
  output logic [IDX_W-1:0]  gnt_id,
  output logic [DATA_W-1:0] result
);

  if (HOLD_MAX < 1) begin : g_bad_hold_max
    $error("HOLD_MAX must be at least 1");
  end

  state_t           state, state_nxt;
  logic [N_REQ-1:0] gnt_nxt;
  logic             valid_nxt;
  logic [IDX_W-1:0] id_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic [IDX_W-1:0] scan_ptr;
  logic [N_REQ-1:0] pick;
  logic [IDX_W-1:0] pick_id;
  logic             pick_any;
  logic             owner_req;
  logic             release_now;

`ifdef ARB_HOLD_LIMIT_EN
  localparam int CNT_W = $clog2(HOLD_MAX + 1);
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             other_req;
`endif

  // While a grant is held, a release always rescans starting just past the owner.
  assign scan_ptr  = (state == GRANT) ? inc_mod(gnt_id) : ptr;
  assign owner_req = |(req & gnt);

  rr_pick5 u_pick (
    .req     (req),
    .ptr     (scan_ptr),
    .pick    (pick),
    .pick_id (pick_id),
    .any     (pick_any)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      ptr       <= '0;
`ifdef ARB_HOLD_LIMIT_EN
      cnt       <= '0;
`endif
    end else begin
      state     <= state_nxt;
      gnt       <= gnt_nxt;
      gnt_valid <= valid_nxt;
      gnt_id    <= id_nxt;
      ptr       <= ptr_nxt;
`ifdef ARB_HOLD_LIMIT_EN
      cnt       <= cnt_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt   = state;
    gnt_nxt     = gnt;
    valid_nxt   = gnt_valid;
    id_nxt      = gnt_id;
    ptr_nxt     = ptr;
    release_now = 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
    cnt_nxt     = cnt;
    other_req   = |(req & ~gnt);
`endif
    case (state)
      IDLE: begin
        if (pick_any) begin
          gnt_nxt   = pick;
          id_nxt    = pick_id;
          valid_nxt = 1'b1;
          state_nxt = GRANT;
`ifdef ARB_HOLD_LIMIT_EN
          cnt_nxt   = CNT_W'(1);
`endif
        end
      end
      GRANT: begin
        release_now = !owner_req;
`ifdef ARB_HOLD_LIMIT_EN
        if ((cnt == CNT_W'(HOLD_MAX)) && other_req) begin
          release_now = 1'b1;
        end
`endif
        if (release_now) begin
          ptr_nxt = inc_mod(gnt_id);
          if (pick_any) begin
            gnt_nxt   = pick;
            id_nxt    = pick_id;
            valid_nxt = 1'b1;
`ifdef ARB_HOLD_LIMIT_EN
            cnt_nxt   = CNT_W'(1);
`endif
          end else begin
            gnt_nxt   = '0;
            id_nxt    = '0;
            valid_nxt = 1'b0;
            state_nxt = IDLE;
`ifdef ARB_HOLD_LIMIT_EN
            cnt_nxt   = '0;
`endif
          end
        end else begin
`ifdef ARB_HOLD_LIMIT_EN
          if (cnt < CNT_W'(HOLD_MAX)) begin
            cnt_nxt = cnt + CNT_W'(1);
          end
`endif
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        valid_nxt = 1'b0;
        id_nxt    = '0;
      end
    endcase
  end

  // AND-OR select on the one-hot grant; zero when nothing is granted.
  always_comb begin
    result = '0;
    result = result | ({DATA_W{gnt[0]}} & data0);
    result = result | ({DATA_W{gnt[1]}} & data1);
    result = result | ({DATA_W{gnt[2]}} & data2);
    result = result | ({DATA_W{gnt[3]}} & data3);
    result = result | ({DATA_W{gnt[4]}} & data4);
  end

endmodule

// File: tb/tb_reg_port_arbiter.sv
// Scoreboard bench for reg_port_arbiter: directed scenarios plus random traffic
// against a queue-based reference model. Honours ARB_HOLD_LIMIT_EN.
module tb_reg_port_arbiter;

  localparam int DATA_W   = 3;
  localparam int HOLD_MAX = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [4:0]        req = '0;
  logic [DATA_W-1:0] data0 = '0, data1 = '0, data2 = '0, data3 = '0, data4 = '0;
  logic [4:0]        gnt;
  logic              gnt_valid;
  logic [2:0]        gnt_id;
  logic [DATA_W-1:0] result;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [4:0] g;
    int         id;
    logic       v;
  } exp_t;

  exp_t expQ[$];
  bit   started = 0;

  int mOwner = -1;
  int mPtr = 0;
  int mTen = 0;

  reg_port_arbiter #(.DATA_W(DATA_W), .HOLD_MAX(HOLD_MAX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .data0     (data0),
    .data1     (data1),
    .data2     (data2),
    .data3     (data3),
    .data4     (data4),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .result    (result)
  );

  always #5 clk = ~clk;

  function automatic int scanFrom(input int p, input logic [4:0] r);
    for (int k = 0; k < 5; k++) begin
      if (r[(p + k) % 5]) return (p + k) % 5;
    end
    return -1;
  endfunction

  function automatic logic [DATA_W-1:0] dataOf(input int id);
    case (id)
      0: return data0;
      1: return data1;
      2: return data2;
      3: return data3;
      default: return data4;
    endcase
  endfunction

  // Reference model: owner/pointer/tenure bookkeeping straight from the arbitration rules.
  always @(posedge clk) begin : model
    int   f;
    bit   rel;
    exp_t e;
    if (!rst_n) begin
      mOwner = -1;
      mPtr   = 0;
      mTen   = 0;
    end else if (mOwner < 0) begin
      f = scanFrom(mPtr, req);
      if (f >= 0) begin
        mOwner = f;
        mTen   = 1;
      end
    end else begin
      rel = !req[mOwner];
`ifdef ARB_HOLD_LIMIT_EN
      if (mTen == HOLD_MAX && ((req & ~(5'b00001 << mOwner)) != 5'b0)) rel = 1;
`endif
      if (rel) begin
        mPtr   = (mOwner + 1) % 5;
        f      = scanFrom(mPtr, req);
        mOwner = f;
        mTen   = (f >= 0) ? 1 : 0;
      end else if (mTen < HOLD_MAX) begin
        mTen = mTen + 1;
      end
    end
    e.v  = (mOwner >= 0);
    e.id = e.v ? mOwner : 0;
    e.g  = e.v ? (5'b00001 << mOwner) : 5'b0;
    expQ.push_back(e);
    started = 1;
  end

  task automatic checkOutput();
    exp_t             e;
    logic [DATA_W-1:0] expRes;
    checks++;
    if (expQ.size() == 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_empty: no expectation queued at t=%0t", $time);
      return;
    end
    e = expQ.pop_front();
    if (gnt !== e.g) begin
      failures++;
      $display("[TB] FAIL gnt: got %b expected %b at t=%0t", gnt, e.g, $time);
    end
    checks++;
    if (gnt_valid !== e.v) begin
      failures++;
      $display("[TB] FAIL gnt_valid: got %b expected %b at t=%0t", gnt_valid, e.v, $time);
    end
    if (e.v) begin
      checks++;
      if (gnt_id !== 3'(e.id)) begin
        failures++;
        $display("[TB] FAIL gnt_id: got %0d expected %0d at t=%0t", gnt_id, e.id, $time);
      end
    end
    expRes = e.v ? dataOf(e.id) : '0;
    checks++;
    if (result !== expRes) begin
      failures++;
      $display("[TB] FAIL result: got %0d expected %0d at t=%0t", result, expRes, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) checkOutput();
  end

  task automatic applyStimulus(input logic rstVal, input logic [4:0] reqVal, input int cycles);
    @(negedge clk);
    #1;
    rst_n = rstVal;
    req   = reqVal;
    repeat (cycles) @(posedge clk);
  endtask

  task automatic randomData();
    data0 = DATA_W'($urandom);
    data1 = DATA_W'($urandom);
    data2 = DATA_W'($urandom);
    data3 = DATA_W'($urandom);
    data4 = DATA_W'($urandom);
  endtask

  initial begin
    logic [4:0] r;
    logic [4:0] flip;
    logic       rs;
    data0 = 3'd1; data1 = 3'd2; data2 = 3'd5; data3 = 3'd6; data4 = 3'd7;

    // reset behaviour, including requests held during reset
    applyStimulus(1'b0, 5'b00000, 2);
    applyStimulus(1'b0, 5'b11111, 2);

    // first grant, then back-to-back handover from 2 to 4, then idle
    applyStimulus(1'b1, 5'b10100, 1);
    applyStimulus(1'b1, 5'b10100, 2);
    applyStimulus(1'b1, 5'b10000, 1);
    applyStimulus(1'b1, 5'b10000, 1);
    applyStimulus(1'b1, 5'b00000, 1);

    // full rotation with wrap: each owner drops for one cycle after its grant
    applyStimulus(1'b0, 5'b00000, 1);
    applyStimulus(1'b1, 5'b11111, 1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 5'b11111 & ~(5'b00001 << i), 1);
    end

    // reset in the middle of requester 3's tenure
    applyStimulus(1'b0, 5'b00000, 1);
    applyStimulus(1'b1, 5'b01000, 3);
    applyStimulus(1'b0, 5'b01000, 1);
    applyStimulus(1'b1, 5'b01001, 2);

    // long tenure with a competitor, then a lone long tenure
    applyStimulus(1'b0, 5'b00000, 1);
    applyStimulus(1'b1, 5'b00010, 2);
    applyStimulus(1'b1, 5'b01010, 12);
    applyStimulus(1'b0, 5'b00000, 1);
    applyStimulus(1'b1, 5'b00010, 20);

    // random traffic: fast-toggling phase, then slow phase for long tenures
    r = 5'b0;
    for (int n = 0; n < 4000; n++) begin
      if (n < 2000) flip = 5'($urandom & $urandom);
      else          flip = 5'($urandom & $urandom & $urandom & $urandom);
      r  = r ^ flip;
      rs = ($urandom_range(0, 99) != 0);
      randomData();
      applyStimulus(rs, r, 1);
    end

    applyStimulus(1'b1, 5'b00000, 2);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
